// File: rtl/mem_bridge_pkg.sv
// Shared types and helpers for the word-to-byte memory bridge.
//  - state_t    : bridge sequencer states
//  - nb()       : number of byte lanes in a data word
//  - next_lane(): lowest enabled lane at or above a start lane
package mem_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        ACCESS = 3'd2,
        GAP    = 3'd3,
        RESP   = 3'd4
    } state_t;

    // Widest word the lane search supports (512-bit data, 64 lanes).
    localparam int MAX_NB = 64;

    function automatic int nb(input int data_w);
        return data_w / 8;
    endfunction

    // Priority search: the lowest lane index >= cur whose enable bit is set.
    // Returns nb_lanes when no enabled lane remains, which callers use as
    // the "all lanes done" marker.
    function automatic int next_lane(input logic [MAX_NB-1:0] be,
                                     input int cur,
                                     input int nb_lanes);
        int res;
        res = nb_lanes;
        // Scan downwards so the lowest qualifying lane is the one left in res.
        for (int i = MAX_NB - 1; i >= 0; i--) begin
            if ((i >= cur) && (i < nb_lanes) && be[i]) begin
                res = i;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state counter for the byte access phase.
// Ports:
//  clk, reset : system clock, synchronous active-high reset
//  load       : reload count with load_val (has priority over dec)
//  load_val   : reload value (number of extra hold cycles)
//  dec        : decrement by one, saturating at zero
//  zero       : count is zero (last cycle of the current hold)
module mem_wait_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count_r;

    // Count register: reload on access entry, otherwise count down to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 4'd0;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != 4'd0)) begin
            count_r <= count_r - 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == 4'd0);

endmodule

// File: rtl/byte_mem_bridge.sv
// Bridge from a word-wide memory request port to a byte-wide external memory.
// One request is split into byte accesses (each held WAIT_CYCLES+1 cycles,
// followed by a one-cycle recovery gap); read bytes are reassembled
// little-endian and writes touch only the byte-enabled lanes.
// Ports:
//  clk, reset           : system clock, synchronous active-high reset
//  req_valid/req_ready  : request handshake (ready only while idle)
//  req_we, req_addr     : write flag, NB-aligned byte address
//  req_wdata, req_be    : write data and byte enables (be ignored on reads)
//  rsp_valid, rsp_err   : one-cycle completion pulse and error flag
//  rsp_rdata            : last completed read word
//  ext_addr, ext_dout   : external byte address and write data
//  ext_din              : external read data
//  ext_ce, ext_we       : external chip enable and write strobe (active high)
module byte_mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int EXT_ADDR_W  = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [EXT_ADDR_W-1:0] ext_addr,
    output logic [7:0]            ext_dout,
    input  logic [7:0]            ext_din,
    output logic                  ext_ce,
    output logic                  ext_we
);

    localparam int NB = nb(DATA_W);
    // One spare bit so the lane index can hold NB ("no lanes left").
    localparam int LANE_W = $clog2(NB) + 1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic [LANE_W-1:0] LANE_DONE = LANE_W'(NB);

    state_t state_r;
    state_t state_next_s;

    logic                  we_r;
    logic [ADDR_W-1:0]     addr_r;
    logic [DATA_W-1:0]     wdata_r;
    logic [NB-1:0]         mask_r;
    logic [LANE_W-1:0]     lane_r;
    logic [LANE_W-1:0]     lane_next_s;
    logic [LANE_W-1:0]     first_lane_s;
    logic [LANE_W-1:0]     after_lane_s;
    logic [DATA_W-1:0]     rdata_acc_r;

    logic                  misalign_s;
    logic                  range_s;
    logic                  err_s;
    logic                  load_s;
    logic                  dec_s;
    logic                  wait_zero_s;

    logic                  req_ready_r;
    logic                  rsp_valid_r;
    logic                  rsp_err_r;
    logic [DATA_W-1:0]     rsp_rdata_r;
    logic [EXT_ADDR_W-1:0] ext_addr_r;
    logic [7:0]            ext_dout_r;
    logic                  ext_ce_r;
    logic                  ext_we_r;

    mem_wait_counter u_wait (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .load_val (WAIT_LOAD),
        .dec      (dec_s),
        .zero     (wait_zero_s)
    );

    // Address legality of the captured request and lane search results.
    always_comb begin
        misalign_s   = ((addr_r & ADDR_W'(NB - 1)) != '0);
        range_s      = ((addr_r >> EXT_ADDR_W) != '0);
        err_s        = misalign_s | range_s;
        first_lane_s = LANE_W'(next_lane(MAX_NB'(mask_r), 0, NB));
        after_lane_s = LANE_W'(next_lane(MAX_NB'(mask_r), int'(lane_r) + 1, NB));
    end

    // Sequencer next-state, lane selection and wait-counter control.
    always_comb begin
        state_next_s = state_r;
        lane_next_s  = lane_r;
        load_s       = 1'b0;
        dec_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_next_s = CHECK;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CHECK: begin
                if (err_s) begin
                    state_next_s = RESP;
                end else if (first_lane_s == LANE_DONE) begin
                    // Write with no byte enables: nothing to do.
                    state_next_s = RESP;
                end else begin
                    state_next_s = ACCESS;
                    lane_next_s  = first_lane_s;
                    load_s       = 1'b1;
                end
            end
            ACCESS: begin
                if (wait_zero_s) begin
                    // Look up the following lane now; GAP only has to test it.
                    state_next_s = GAP;
                    lane_next_s  = after_lane_s;
                end else begin
                    state_next_s = ACCESS;
                    dec_s        = 1'b1;
                end
            end
            GAP: begin
                if (lane_r == LANE_DONE) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = ACCESS;
                    load_s       = 1'b1;
                end
            end
            RESP: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, lane index and captured request fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            lane_r  <= '0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            mask_r  <= '0;
        end else begin
            state_r <= state_next_s;
            lane_r  <= lane_next_s;
            if (state_r == IDLE && req_valid) begin
                we_r    <= req_we;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
                // Reads walk every lane; writes only the enabled ones.
                mask_r  <= req_we ? req_be : {NB{1'b1}};
            end else begin
                we_r    <= we_r;
                addr_r  <= addr_r;
                wdata_r <= wdata_r;
                mask_r  <= mask_r;
            end
        end
    end

    // Read assembly: capture ext_din into the current lane on the last hold cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_acc_r <= '0;
        end else if (state_r == IDLE && req_valid) begin
            rdata_acc_r <= '0;
        end else if (state_r == ACCESS && wait_zero_s && !we_r) begin
            rdata_acc_r[{lane_r, 3'b000} +: 8] <= ext_din;
        end else begin
            rdata_acc_r <= rdata_acc_r;
        end
    end

    // External pins, registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_ce_r   <= 1'b0;
            ext_we_r   <= 1'b0;
            ext_addr_r <= '0;
            ext_dout_r <= 8'd0;
        end else begin
            ext_ce_r <= (state_next_s == ACCESS);
            ext_we_r <= (state_next_s == ACCESS) && we_r;
            if (load_s) begin
                ext_addr_r <= EXT_ADDR_W'(addr_r) + EXT_ADDR_W'(lane_next_s);
                ext_dout_r <= wdata_r[{lane_next_s, 3'b000} +: 8];
            end else begin
                ext_addr_r <= ext_addr_r;
                ext_dout_r <= ext_dout_r;
            end
        end
    end

    // Request/response port registers.
    // rsp_rdata is cleared by reset only when the bridge is idle, so a reset
    // that aborts a transfer keeps the last completed read word visible;
    // a reset held for two or more cycles always clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            if (state_r == IDLE) begin
                rsp_rdata_r <= '0;
            end else begin
                rsp_rdata_r <= rsp_rdata_r;
            end
        end else begin
            req_ready_r <= (state_next_s == IDLE);
            rsp_valid_r <= (state_next_s == RESP);
            rsp_err_r   <= (state_r == CHECK) && err_s;
            // Only a read that walked its lanes arrives at RESP from GAP.
            if (state_r == GAP && state_next_s == RESP && !we_r) begin
                rsp_rdata_r <= rdata_acc_r;
            end else begin
                rsp_rdata_r <= rsp_rdata_r;
            end
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_rdata = rsp_rdata_r;
    assign ext_addr  = ext_addr_r;
    assign ext_dout  = ext_dout_r;
    assign ext_ce    = ext_ce_r;
    assign ext_we    = ext_we_r;

endmodule

// File: tb/tb_byte_mem_bridge.sv
// Self-checking bench for byte_mem_bridge: a 32-bit / 2-wait-state instance
// driven from a vector table, plus a 64-bit / 0-wait-state instance for the
// back-to-back handshake case.
module tb_byte_mem_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // ---------------- instance A: DATA_W=32, WAIT_CYCLES=2 ----------------
    logic        a_req_valid, a_req_ready, a_req_we;
    logic [31:0] a_req_addr, a_req_wdata;
    logic [3:0]  a_req_be;
    logic        a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic [15:0] a_ext_addr;
    logic [7:0]  a_ext_dout, a_ext_din;
    logic        a_ext_ce, a_ext_we;

    byte_mem_bridge #(.DATA_W(32), .ADDR_W(32), .EXT_ADDR_W(16), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
        .rsp_valid(a_rsp_valid), .rsp_err(a_rsp_err), .rsp_rdata(a_rsp_rdata),
        .ext_addr(a_ext_addr), .ext_dout(a_ext_dout), .ext_din(a_ext_din),
        .ext_ce(a_ext_ce), .ext_we(a_ext_we)
    );

    // ---------------- instance B: DATA_W=64, WAIT_CYCLES=0 ----------------
    logic        b_req_valid, b_req_ready, b_req_we;
    logic [31:0] b_req_addr;
    logic [63:0] b_req_wdata;
    logic [7:0]  b_req_be;
    logic        b_rsp_valid, b_rsp_err;
    logic [63:0] b_rsp_rdata;
    logic [15:0] b_ext_addr;
    logic [7:0]  b_ext_dout, b_ext_din;
    logic        b_ext_ce, b_ext_we;

    byte_mem_bridge #(.DATA_W(64), .ADDR_W(32), .EXT_ADDR_W(16), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .rsp_valid(b_rsp_valid), .rsp_err(b_rsp_err), .rsp_rdata(b_rsp_rdata),
        .ext_addr(b_ext_addr), .ext_dout(b_ext_dout), .ext_din(b_ext_din),
        .ext_ce(b_ext_ce), .ext_we(b_ext_we)
    );

    // ---------------- byte device models and activity monitors ----------------
    logic [7:0] mem_a [0:255];
    logic [7:0] mem_b [0:255];
    assign a_ext_din = mem_a[a_ext_addr[7:0]];
    assign b_ext_din = mem_b[b_ext_addr[7:0]];

    int          a_ce_cycles = 0;
    int          a_we_bursts = 0;
    int          b_ce_cycles = 0;
    int          b_accesses  = 0;
    logic        a_ce_prev   = 1'b0;
    logic        a_we_prev   = 1'b0;
    logic        b_ce_prev   = 1'b0;
    logic [15:0] a_addr_q[$];

    // Device contents are loaded while reset is high; writes land on ce&&we.
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= 8'h00;
                mem_b[i] <= 8'(8'h30 + i);
            end
            mem_a[8'h10] <= 8'h11; mem_a[8'h11] <= 8'h22;
            mem_a[8'h12] <= 8'h33; mem_a[8'h13] <= 8'h44;
            mem_a[8'h14] <= 8'h01; mem_a[8'h15] <= 8'h02;
            mem_a[8'h16] <= 8'h03; mem_a[8'h17] <= 8'hEE;
            mem_a[8'h20] <= 8'h55; mem_a[8'h21] <= 8'h66;
            mem_a[8'h22] <= 8'h77; mem_a[8'h23] <= 8'h88;
        end else begin
            if (a_ext_ce && a_ext_we) mem_a[a_ext_addr[7:0]] <= a_ext_dout;
            if (b_ext_ce && b_ext_we) mem_b[b_ext_addr[7:0]] <= b_ext_dout;
        end
        if (a_ext_ce) a_ce_cycles <= a_ce_cycles + 1;
        if (a_ext_ce && !a_ce_prev) a_addr_q.push_back(a_ext_addr);
        if (a_ext_we && !a_we_prev) a_we_bursts <= a_we_bursts + 1;
        if (b_ext_ce) b_ce_cycles <= b_ce_cycles + 1;
        if (b_ext_ce && !b_ce_prev) b_accesses <= b_accesses + 1;
        a_ce_prev <= a_ext_ce;
        a_we_prev <= a_ext_we;
        b_ce_prev <= b_ext_ce;
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        err;
        logic [31:0] rdata;      // rsp_rdata expected after the response
        int          lat;        // cycle index of the rsp_valid pulse
        int          acc;        // number of ext_ce bursts
        int          ce_cyc;     // total ext_ce-high cycles
        int          we_bursts;  // number of ext_we bursts
        logic [15:0] first_addr;
        logic [15:0] last_addr;
    } vec_t;

    vec_t vecs [9];

    // Issue one request on instance A and check timing, data and pin activity.
    task automatic run_a(input int idx, input vec_t v);
        int  start_q, start_ce, start_we, n, acc;
        bit  got;
        string tag;
        tag      = $sformatf("v%0d", idx);
        start_q  = a_addr_q.size();
        start_ce = a_ce_cycles;
        start_we = a_we_bursts;
        @(negedge clk);
        check({tag, "_ready"}, a_req_ready, 1);
        a_req_we    = v.we;
        a_req_addr  = v.addr;
        a_req_wdata = v.wdata;
        a_req_be    = v.be;
        a_req_valid = 1'b1;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (a_rsp_valid) got = 1'b1;
        end
        check({tag, "_latency"}, n, v.lat);
        check({tag, "_err"}, a_rsp_err, v.err);
        check({tag, "_rdata"}, a_rsp_rdata, v.rdata);
        @(negedge clk);
        check({tag, "_pulse_end"}, a_rsp_valid, 0);
        acc = a_addr_q.size() - start_q;
        check({tag, "_accesses"}, acc, v.acc);
        check({tag, "_ce_cycles"}, a_ce_cycles - start_ce, v.ce_cyc);
        check({tag, "_we_bursts"}, a_we_bursts - start_we, v.we_bursts);
        if (v.acc > 0 && acc >= v.acc) begin
            check({tag, "_first_addr"}, a_addr_q[start_q], v.first_addr);
            check({tag, "_last_addr"}, a_addr_q[start_q + v.acc - 1], v.last_addr);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rsp_seen, busy_ready, ce_before;
        bit got;

        //            we    addr          wdata         be     err   rdata         lat acc ce we first   last
        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,        4'h0,  1'b0, 32'h44332211, 18, 4, 12, 0, 16'h10, 16'h13};
        vecs[1] = '{1'b1, 32'h0000_0020, 32'hAABBCCDD, 4'h5,  1'b0, 32'h44332211, 10, 2, 6,  2, 16'h20, 16'h22};
        vecs[2] = '{1'b0, 32'h0000_0022, 32'h0,        4'h0,  1'b1, 32'h44332211, 2,  0, 0,  0, 16'h0,  16'h0};
        vecs[3] = '{1'b0, 32'h0001_0000, 32'h0,        4'h0,  1'b1, 32'h44332211, 2,  0, 0,  0, 16'h0,  16'h0};
        vecs[4] = '{1'b1, 32'h0000_0024, 32'hFFFFFFFF, 4'h0,  1'b0, 32'h44332211, 2,  0, 0,  0, 16'h0,  16'h0};
        vecs[5] = '{1'b0, 32'h0000_0020, 32'h0,        4'h0,  1'b0, 32'h88BB66DD, 18, 4, 12, 0, 16'h20, 16'h23};
        vecs[6] = '{1'b1, 32'h0000_0014, 32'h12345678, 4'h8,  1'b0, 32'h88BB66DD, 6,  1, 3,  1, 16'h17, 16'h17};
        vecs[7] = '{1'b0, 32'h0000_0014, 32'h0,        4'h0,  1'b0, 32'h12030201, 18, 4, 12, 0, 16'h14, 16'h17};
        vecs[8] = '{1'b1, 32'h0000_0021, 32'h01020304, 4'hF,  1'b1, 32'h12030201, 2,  0, 0,  0, 16'h0,  16'h0};

        reset       = 1'b1;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ready",     a_req_ready, 1);
        check("rst_rsp_valid", a_rsp_valid, 0);
        check("rst_rsp_err",   a_rsp_err,   0);
        check("rst_rdata",     a_rsp_rdata, 0);
        check("rst_ce",        a_ext_ce,    0);
        check("rst_we",        a_ext_we,    0);
        check("rst_ext_addr",  a_ext_addr,  0);
        check("rst_ext_dout",  a_ext_dout,  0);
        check("rst_b_ready",   b_req_ready, 1);
        check("rst_b_rdata",   b_rsp_rdata, 0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_a(i, vecs[i]);

        // Reset during lane 2 ACCESS of a read of 0x20.
        @(negedge clk);
        a_req_we = 1'b0; a_req_addr = 32'h20; a_req_be = 4'h0; a_req_valid = 1'b1;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_ce",   a_ext_ce, 1);
        check("mid_addr", a_ext_addr, 16'h22);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_ce",     a_ext_ce,    0);
        check("abort_we",     a_ext_we,    0);
        check("abort_ready",  a_req_ready, 1);
        check("abort_rsp",    a_rsp_valid, 0);
        check("abort_rdata",  a_rsp_rdata, 32'h12030201);
        rsp_seen  = 0;
        ce_before = a_ce_cycles;
        repeat (25) begin
            @(negedge clk);
            if (a_rsp_valid) rsp_seen++;
        end
        check("abort_no_rsp",   rsp_seen, 0);
        check("abort_no_ce",    a_ce_cycles - ce_before, 0);
        check("abort_rdata_hold", a_rsp_rdata, 32'h12030201);
        run_a(9, vecs[0]);

        // Instance B: 8 lanes, no wait states, req_valid held high throughout.
        @(negedge clk);
        check("b_ready0", b_req_ready, 1);
        b_req_we = 1'b0; b_req_addr = 32'h0; b_req_be = 8'h00; b_req_valid = 1'b1;
        @(posedge clk);
        #1 b_req_addr = 32'h8;
        n = 0; got = 1'b0; busy_ready = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (b_rsp_valid) got = 1'b1;
            else if (b_req_ready) busy_ready++;
        end
        check("b_latency1", n, 18);
        check("b_rdata1",   b_rsp_rdata, 64'h3736353433323130);
        check("b_err1",     b_rsp_err, 0);
        check("b_busy_ignored", busy_ready, 0);
        @(negedge clk);
        check("b_ready_after_resp", b_req_ready, 1);
        @(posedge clk);
        #1 b_req_valid = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (b_rsp_valid) got = 1'b1;
        end
        check("b_latency2", n, 18);
        check("b_rdata2",   b_rsp_rdata, 64'h3F3E3D3C3B3A3938);
        check("b_ce_cycles", b_ce_cycles, 16);
        check("b_accesses",  b_accesses, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
